// File: rtl/regfile_pkg.sv
// Shared defaults and ABI register indices for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, writes clear it, and a
// reservation landing in the same cycle as a write to that register wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_WR   = NUM_WR_DEF,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  output logic [NUM_REGS-1:0]          busy,
  output logic [AW:0]                  busy_cnt
);

  logic [NUM_REGS-1:0] busy_next;
  logic [AW:0]         cnt_next;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_reg
      logic clr;
      always_comb begin
        clr = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w] == AW'(gi)) clr = 1'b1;
        end
      end
      assign busy_next[gi] = (rsv_en && rsv_addr == AW'(gi)) || (busy[gi] && !clr);
    end
  end

  // Count from the next-state vector so busy_cnt tracks busy on the same edge.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register, same-cycle write
// bypass on every read port and a busy scoreboard for pending producers.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = NUM_RD_DEF,
  parameter  int NUM_WR   = NUM_WR_DEF,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           rsv_en,
  input  logic [AW-1:0]                  rsv_addr,
  output logic [AW:0]                    busy_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Later ports override earlier ones in the loop, so the highest index wins.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_store
    if (gi == 0) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] q_reg;
      logic [DATA_W-1:0] d_next;
      always_comb begin
        d_next = q_reg;
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w] == AW'(gi)) d_next = wr_data[w];
        end
      end
      always_ff @(posedge clock or posedge reset) begin
        if (reset) q_reg <= '0;
        else       q_reg <= d_next;
      end
      assign regs[gi] = q_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_read
    logic              hit;
    logic [DATA_W-1:0] d;
    always_comb begin
      hit = 1'b0;
      d   = regs[rd_addr[gi]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && rd_addr[gi] != '0 && wr_addr[w] == rd_addr[gi]) begin
          hit = 1'b1;
          d   = wr_data[w];
        end
      end
    end
    // Reset masks the bypass path too, since writes are being ignored.
    assign rd_data[gi] = reset ? '0 : d;
    assign rd_busy[gi] = !reset && busy[rd_addr[gi]] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass, collisions, zero register, scoreboard, reset.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [1:0][AW-1:0]    rd_addr;
  logic [1:0][DW-1:0]    rd_data;
  logic [1:0]            rd_busy;
  logic [1:0]            wr_en;
  logic [1:0][AW-1:0]    wr_addr;
  logic [1:0][DW-1:0]    wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic [AW:0]           busy_cnt;

  int n_pass = 0;
  int n_total = 0;

  regfile_mp dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge and settle; inputs are then changed well clear of the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    #2;
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    // Write and reserve attempted while reset is high must be ignored.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hAAAA_5555;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    rd_addr[0] = 5'd5;
    #1;
    chk("rst_rdata", 64'(rd_data[0]), 64'd0);
    chk("rst_rbusy", 64'(rd_busy), 64'd0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_ignwr", 64'(rd_data[0]), 64'd0);
    chk("rst_ignrsv", 64'(busy_cnt), 64'd0);

    // Basic write then read on both ports.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    tick();
    idle();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    #1;
    chk("wr_r5_p0", 64'(rd_data[0]), 64'hDEAD_BEEF);
    chk("wr_r5_p1", 64'(rd_data[1]), 64'hDEAD_BEEF);

    // Collision: port 1 wins, visible through bypass and in storage.
    wr_en = 2'b11;
    wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
    wr_addr[1] = 5'd7; wr_data[1] = 32'h22;
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd5;
    #1;
    chk("coll_byp", 64'(rd_data[0]), 64'h22);
    chk("nobyp_r5", 64'(rd_data[1]), 64'hDEAD_BEEF);
    tick();
    idle();
    #1;
    chk("coll_store", 64'(rd_data[0]), 64'h22);

    // Zero register ignores writes and reservations.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr[0] = 5'd0;
    #1;
    chk("r0_byp", 64'(rd_data[0]), 64'd0);
    chk("r0_rbusy", 64'(rd_busy[0]), 64'd0);
    tick();
    idle();
    #1;
    chk("r0_data", 64'(rd_data[0]), 64'd0);
    chk("r0_cnt", 64'(busy_cnt), 64'd0);

    // Scoreboard on r8: reserve, reserve+write, re-reserve, write.
    rsv_en = 1'b1; rsv_addr = 5'd8;
    tick();
    idle();
    rd_addr[0] = 5'd8;
    #1;
    chk("r8_busy", 64'(rd_busy[0]), 64'd1);
    chk("r8_cnt1", 64'(busy_cnt), 64'd1);
    rsv_en = 1'b1; rsv_addr = 5'd8;
    wr_en[1] = 1'b1; wr_addr[1] = 5'd8; wr_data[1] = 32'h55;
    #1;
    chk("r8_samecyc", 64'(rd_busy[0]), 64'd0);
    tick();
    idle();
    #1;
    chk("r8_rsvwr_bz", 64'(rd_busy[0]), 64'd1);
    chk("r8_rsvwr_dt", 64'(rd_data[0]), 64'h55);
    chk("r8_rsvwr_ct", 64'(busy_cnt), 64'd1);
    rsv_en = 1'b1; rsv_addr = 5'd8;
    tick();
    idle();
    #1;
    chk("r8_dblrsv", 64'(busy_cnt), 64'd1);
    wr_en[0] = 1'b1; wr_addr[0] = 5'd8; wr_data[0] = 32'h66;
    tick();
    idle();
    #1;
    chk("r8_clr_bz", 64'(rd_busy[0]), 64'd0);
    chk("r8_clr_cnt", 64'(busy_cnt), 64'd0);
    chk("r8_clr_dt", 64'(rd_data[0]), 64'h66);

    // Busy r9 read on port 1 while being written.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    rd_addr[1] = 5'd9;
    #1;
    chk("r9_busy", 64'(rd_busy[1]), 64'd1);
    wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h1234;
    #1;
    chk("r9_byp_dt", 64'(rd_data[1]), 64'h1234);
    chk("r9_byp_bz", 64'(rd_busy[1]), 64'd0);
    tick();
    idle();
    #1;
    chk("r9_cnt", 64'(busy_cnt), 64'd0);

    // Write to a non-busy register with a reservation elsewhere.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 32'h0A0A;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    idle();
    rd_addr[0] = 5'd10; rd_addr[1] = 5'd12;
    #1;
    chk("r10_nbz", 64'(rd_busy[0]), 64'd0);
    chk("r10_data", 64'(rd_data[0]), 64'h0A0A);
    chk("r12_busy", 64'(rd_busy[1]), 64'd1);

    // Reserve r3..r5 then assert reset between edges.
    for (int a = 3; a <= 5; a++) begin
      rsv_en = 1'b1; rsv_addr = AW'(a);
      tick();
    end
    idle();
    #1;
    chk("rsv3_cnt", 64'(busy_cnt), 64'd4);
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
    chk("mid_rst_r5", 64'(rd_data[0]), 64'd0);
    chk("mid_rst_r7", 64'(rd_data[1]), 64'd0);
    tick();
    reset = 1'b0;
    rd_addr[0] = 5'd8; rd_addr[1] = 5'd4;
    tick();
    chk("post_r8", 64'(rd_data[0]), 64'd0);
    chk("post_r4bz", 64'(rd_busy[1]), 64'd0);
    chk("post_cnt", 64'(busy_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
